// File: rtl/axis_tail_fold.sv
// Valid/ready stream stage that adds the reversed last-K beats of the previous packet
// to the first K beats of the current one, using ping-pong history banks.
module axis_tail_fold #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned MAX_K  = 16,
  parameter int unsigned K_W    = $clog2(MAX_K) + 1
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_valid,
  input  logic              s_last,
  output logic              s_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  output logic              m_last,
  input  logic              m_ready,
  input  logic              cfg_en,
  input  logic [K_W-1:0]    cfg_k,
  input  logic              cfg_sat,
  output logic              sat_pulse
);

  localparam int unsigned PW = $clog2(MAX_K);

  logic [DATA_W-1:0] hist_q [2][MAX_K];

  logic           bank_sel_q, bank_sel_d;
  logic [PW-1:0]  wp_q, wp_d, rd_ptr_q, rd_ptr_d;
  logic [K_W-1:0] wcnt_q, wcnt_d, fold_left_q, fold_left_d, k_lat_q, k_lat_d;
  logic           en_lat_q, en_lat_d, in_pkt_q, in_pkt_d;

  logic [DATA_W-1:0] m_data_d;
  logic              m_valid_d, m_last_d, sat_pulse_d;

  logic              accept, fold_act, en_cur, sat;
  logic [K_W-1:0]    k_clamp, k_cur, wcnt_inc;
  logic [DATA_W-1:0] addend;
  logic [DATA_W:0]   sum;

  assign s_ready = !m_valid || m_ready;
  assign accept  = s_valid && s_ready;

  // The first beat of a packet uses live config; later beats use the latched copy.
  assign k_clamp  = (cfg_k > K_W'(MAX_K)) ? K_W'(MAX_K) : cfg_k;
  assign k_cur    = in_pkt_q ? k_lat_q : k_clamp;
  assign en_cur   = in_pkt_q ? en_lat_q : cfg_en;
  assign wcnt_inc = (wcnt_q == K_W'(MAX_K)) ? wcnt_q : wcnt_q + K_W'(1);

  assign fold_act = (fold_left_q != '0) && (k_cur != '0) && en_cur;
  assign addend   = fold_act ? hist_q[~bank_sel_q][rd_ptr_q] : '0;
  assign sum      = {1'b0, s_data} + {1'b0, addend};
  assign sat      = cfg_sat && sum[DATA_W];

  always_comb begin
    bank_sel_d  = bank_sel_q;
    wp_d        = wp_q;
    rd_ptr_d    = rd_ptr_q;
    wcnt_d      = wcnt_q;
    fold_left_d = fold_left_q;
    k_lat_d     = k_lat_q;
    en_lat_d    = en_lat_q;
    in_pkt_d    = in_pkt_q;
    if (accept) begin
      wp_d     = wp_q + PW'(1);
      wcnt_d   = wcnt_inc;
      k_lat_d  = k_cur;
      en_lat_d = en_cur;
      in_pkt_d = !s_last;
      if (fold_act) begin
        rd_ptr_d    = rd_ptr_q - PW'(1);
        fold_left_d = fold_left_q - K_W'(1);
      end
      if (s_last) begin
        // Any residual fold of the current packet is dropped here.
        bank_sel_d  = ~bank_sel_q;
        rd_ptr_d    = wp_q;
        fold_left_d = (k_cur < wcnt_inc) ? k_cur : wcnt_inc;
        wp_d        = '0;
        wcnt_d      = '0;
      end
    end
  end

  always_comb begin
    m_valid_d   = m_valid;
    m_data_d    = m_data;
    m_last_d    = m_last;
    sat_pulse_d = 1'b0;
    if (accept) begin
      m_valid_d   = 1'b1;
      m_data_d    = sat ? '1 : sum[DATA_W-1:0];
      m_last_d    = s_last;
      sat_pulse_d = sat;
    end else if (m_ready) begin
      m_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      bank_sel_q  <= 1'b0;
      wp_q        <= '0;
      rd_ptr_q    <= '0;
      wcnt_q      <= '0;
      fold_left_q <= '0;
      k_lat_q     <= '0;
      en_lat_q    <= 1'b0;
      in_pkt_q    <= 1'b0;
      m_valid     <= 1'b0;
      m_data      <= '0;
      m_last      <= 1'b0;
      sat_pulse   <= 1'b0;
    end else begin
      bank_sel_q  <= bank_sel_d;
      wp_q        <= wp_d;
      rd_ptr_q    <= rd_ptr_d;
      wcnt_q      <= wcnt_d;
      fold_left_q <= fold_left_d;
      k_lat_q     <= k_lat_d;
      en_lat_q    <= en_lat_d;
      in_pkt_q    <= in_pkt_d;
      m_valid     <= m_valid_d;
      m_data      <= m_data_d;
      m_last      <= m_last_d;
      sat_pulse   <= sat_pulse_d;
    end
  end

  // History storage needs no reset: fold_left gates every read.
  always_ff @(posedge clk) begin
    if (accept) begin
      hist_q[bank_sel_q][wp_q] <= s_data;
    end
  end

endmodule

// File: tb/tb_axis_tail_fold.sv
// Randomized and directed bench for axis_tail_fold against a packet-level reference model.
module tb_axis_tail_fold;

  localparam int DW = 8;
  localparam int MK = 8;
  localparam int KW = 4;

  logic          clk = 1'b0;
  logic          resetn;
  logic [DW-1:0] s_data;
  logic          s_valid, s_last, s_ready;
  logic [DW-1:0] m_data;
  logic          m_valid, m_last, m_ready;
  logic          cfg_en, cfg_sat, sat_pulse;
  logic [KW-1:0] cfg_k;

  axis_tail_fold #(.DATA_W(DW), .MAX_K(MK), .K_W(KW)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .s_data    (s_data),
    .s_valid   (s_valid),
    .s_last    (s_last),
    .s_ready   (s_ready),
    .m_data    (m_data),
    .m_valid   (m_valid),
    .m_last    (m_last),
    .m_ready   (m_ready),
    .cfg_en    (cfg_en),
    .cfg_k     (cfg_k),
    .cfg_sat   (cfg_sat),
    .sat_pulse (sat_pulse)
  );

  always #5 clk = ~clk;

  typedef struct {logic [7:0] d; logic last; logic [3:0] k; logic en; logic sat;} stim_t;
  typedef struct {logic [7:0] d; logic last; logic sat;} exp_t;

  stim_t      stim_q[$];
  exp_t       exp_q[$];
  logic [9:0] obs_q[$];
  logic [9:0] gold_q[$];
  logic [9:0] obs_a[$];

  // Reference model state: packets as plain byte lists.
  logic [7:0] prev_pkt[$];
  logic [7:0] cur_pkt[$];
  int         m_fold, m_k, m_idx;
  bit         m_en, m_in_pkt;

  int checks = 0;
  int errors = 0;
  int cur_k = 3;
  bit cur_en = 1, cur_sat = 0;
  bit pend_acc, pend_sat;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic beat(input int d, input bit last);
    stim_t s;
    s.d = 8'(d); s.last = last; s.k = 4'(cur_k); s.en = cur_en; s.sat = cur_sat;
    stim_q.push_back(s);
  endtask

  task automatic gold(input int d, input bit last, input bit sat);
    gold_q.push_back({sat, last, 8'(d)});
  endtask

  task automatic model_accept(input stim_t s);
    int addend, sum;
    exp_t e;
    if (!m_in_pkt) begin
      m_k = (int'(s.k) > MK) ? MK : int'(s.k);
      m_en = s.en; m_idx = 0; cur_pkt.delete();
    end
    addend = (m_en && m_k != 0 && m_idx < m_fold) ? int'(prev_pkt[prev_pkt.size()-1-m_idx]) : 0;
    sum = int'(s.d) + addend;
    e.last = s.last;
    if (s.sat && sum > 255) begin e.d = 8'hff; e.sat = 1'b1; end
    else begin e.d = 8'(sum); e.sat = 1'b0; end
    exp_q.push_back(e);
    cur_pkt.push_back(s.d);
    m_idx++;
    if (s.last) begin
      prev_pkt = cur_pkt;
      m_fold = (m_k < cur_pkt.size()) ? m_k : cur_pkt.size();
      m_in_pkt = 0;
    end else m_in_pkt = 1;
  endtask

  task automatic do_reset();
    s_valid = 1'b1; s_data = 8'h5a; s_last = 1'b0; m_ready = 1'b0;
    resetn = 1'b0;
    #1;
    check_eq("rst_m_valid", m_valid, 0);
    check_eq("rst_m_data", m_data, 0);
    check_eq("rst_m_last", m_last, 0);
    check_eq("rst_sat", sat_pulse, 0);
    check_eq("rst_s_ready", s_ready, 1);
    s_valid = 1'b0; m_ready = 1'b1;
    stim_q.delete(); exp_q.delete(); obs_q.delete(); gold_q.delete();
    prev_pkt.delete(); cur_pkt.delete();
    m_fold = 0; m_in_pkt = 0; pend_acc = 0;
    @(negedge clk);
    @(negedge clk);
    resetn = 1'b1;
  endtask

  // mode 0: m_ready high, 1: alternating, 2: random with source gaps.
  task automatic run(input int mode, input int max_cyc, input bit expect_done);
    int cyc = 0;
    bit held = 0, tog = 0;
    while ((stim_q.size() > 0 || exp_q.size() > 0) && cyc < max_cyc) begin
      @(negedge clk);
      s_valid = (stim_q.size() > 0) && (held || mode != 2 || $urandom_range(0, 3) != 0);
      if (stim_q.size() > 0) begin
        s_data = stim_q[0].d; s_last = stim_q[0].last; cfg_k = stim_q[0].k;
        cfg_en = stim_q[0].en; cfg_sat = stim_q[0].sat;
      end
      tog = ~tog;
      m_ready = (mode == 0) ? 1'b1 : (mode == 1) ? tog : ($urandom_range(0, 3) != 0);
      #1;
      if (pend_acc || sat_pulse) check_eq("sat_pulse", sat_pulse, pend_acc ? pend_sat : 1'b0);
      if (m_valid) begin
        check_eq("beat_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          check_eq("m_data", m_data, exp_q[0].d);
          check_eq("m_last", m_last, exp_q[0].last);
          if (m_ready) begin
            obs_q.push_back({sat_pulse, m_last, m_data});
            void'(exp_q.pop_front());
          end
        end
      end
      pend_acc = 0;
      if (s_valid && s_ready) begin
        model_accept(stim_q[0]);
        pend_acc = 1; pend_sat = exp_q[$].sat;
        void'(stim_q.pop_front());
        held = 0;
      end else held = s_valid;
      cyc++;
    end
    s_valid = 1'b0; m_ready = 1'b1;
    if (expect_done) check_eq("drain", stim_q.size() + exp_q.size(), 0);
  endtask

  task automatic compare_gold(input string tag);
    check_eq({tag, "_count"}, obs_q.size(), gold_q.size());
    foreach (gold_q[i]) if (i < obs_q.size()) check_eq($sformatf("%s_%0d", tag, i), obs_q[i], gold_q[i]);
    obs_q.delete(); gold_q.delete();
  endtask

  initial begin
    s_valid = 0; s_data = 0; s_last = 0; m_ready = 1;
    cfg_en = 1; cfg_k = 3; cfg_sat = 0;
    do_reset();

    // Basic fold.
    cur_k = 3; cur_en = 1; cur_sat = 0;
    for (int i = 1; i <= 6; i++) beat(i, i == 6);
    for (int i = 0; i < 4; i++) beat(10, i == 3);
    for (int i = 1; i <= 6; i++) gold(i, i == 6, 0);
    gold(16, 0, 0); gold(15, 0, 0); gold(14, 0, 0); gold(10, 1, 0);
    run(0, 100, 1);
    compare_gold("basic");

    // Wrap vs saturate.
    do_reset();
    cur_k = 1; cur_sat = 0; beat(200, 1); beat(100, 1);
    gold(200, 1, 0); gold(44, 1, 0);
    run(0, 50, 1);
    compare_gold("wrap");
    do_reset();
    cur_k = 1; cur_sat = 1; beat(200, 1); beat(100, 1);
    gold(200, 1, 0); gold(255, 1, 1);
    run(0, 50, 1);
    compare_gold("satur");

    // Short previous packet, then reversed tail of a short packet.
    do_reset();
    cur_k = 4; cur_sat = 0;
    beat(7, 1); beat(1, 0); beat(1, 0); beat(1, 1); beat(0, 0); beat(0, 1);
    gold(7, 1, 0); gold(8, 0, 0); gold(1, 0, 0); gold(1, 1, 0); gold(1, 0, 0); gold(1, 1, 0);
    run(0, 50, 1);
    compare_gold("short");

    // Back-pressure: same packets with and without stalls must match.
    cur_k = 3;
    for (int pass = 0; pass < 2; pass++) begin
      do_reset();
      void'($urandom(32'h1234));
      for (int i = 0; i < 12; i++) beat($urandom_range(0, 255), i == 5 || i == 11);
      run(pass, 200, 1);
      if (pass == 0) begin obs_a = obs_q; obs_q.delete(); end
    end
    check_eq("stall_count", obs_q.size(), obs_a.size());
    foreach (obs_a[i]) if (i < obs_q.size()) check_eq($sformatf("stall_%0d", i), obs_q[i], obs_a[i]);
    obs_q.delete();

    // Reset mid-packet discards history.
    do_reset();
    for (int i = 1; i <= 6; i++) beat(i, i == 6);
    run(0, 4, 0);
    do_reset();
    beat(5, 0); beat(5, 1);
    gold(5, 0, 0); gold(5, 1, 0);
    run(0, 50, 1);
    compare_gold("midrst");

    // Disable keeps capturing; k=0 passes through.
    do_reset();
    cur_k = 3; cur_en = 1;
    beat(1, 0); beat(2, 0); beat(3, 1);
    cur_en = 0; beat(10, 0); beat(20, 0); beat(30, 1);
    cur_en = 1; beat(1, 0); beat(1, 0); beat(1, 1);
    cur_k = 0; beat(5, 0); beat(5, 1);
    gold(1, 0, 0); gold(2, 0, 0); gold(3, 1, 0);
    gold(10, 0, 0); gold(20, 0, 0); gold(30, 1, 0);
    gold(31, 0, 0); gold(21, 0, 0); gold(11, 1, 0);
    gold(5, 0, 0); gold(5, 1, 0);
    run(0, 100, 1);
    compare_gold("enable");

    // Randomized traffic, config, lengths and back-pressure.
    do_reset();
    for (int p = 0; p < 200; p++) begin
      int len;
      len = $urandom_range(1, 12);
      cur_k = $urandom_range(0, 15);
      cur_en = ($urandom_range(0, 4) != 0);
      cur_sat = $urandom_range(0, 1);
      for (int i = 0; i < len; i++) beat($urandom_range(0, 255), i == len - 1);
    end
    run(2, 20000, 1);
    obs_q.delete();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/axis_tail_fold.md
# axis_tail_fold

Parametrised stream block that captures the last K beats of every packet and adds them, in reverse order, to the first K beats of the following packet. It generalises the earlier fixed 8-bit tail-fold stage with configurable data width, history depth and overflow mode, proper ping-pong history storage and full valid/ready back-pressure. It sits inline on a valid/ready/last stream between a packet source and its consumer.

## Interface
- DATA_W, 8, data width in bits
- MAX_K, 16, history depth per bank, power of two ≥ 2
- K_W, $clog2(MAX_K)+1, width of cfg_k
- clk  in  1  clock, rising edge
- resetn  in  1  asynchronous active-low reset
- s_data  in  DATA_W  input beat data
- s_valid  in  1  input beat valid
- s_last  in  1  last beat of input packet
- s_ready  out  1  block can accept a beat
- m_data  out  DATA_W  output beat data
- m_valid  out  1  output beat valid
- m_last  out  1  last beat of output packet
- m_ready  in  1  downstream accepts beat
- cfg_en  in  1  1 = fold enabled, 0 = passthrough (capture continues)
- cfg_k  in  K_W  fold length; values > MAX_K clamp to MAX_K
- cfg_sat  in  1  0 = wrap-around add, 1 = unsigned saturating add
- sat_pulse  out  1  one-cycle pulse when an output beat saturated

## Operation
- Accept: beat accepted when s_valid && s_ready. s_ready = !m_valid || m_ready (combinational).
- Two history banks of MAX_K × DATA_W; wr_bank captures the current packet, the other is rd_bank.
- Capture: every accepted beat written to wr_bank[wp], wp increments mod MAX_K; wcnt increments, saturating at MAX_K.
- On accepted s_last: swap banks; rd_ptr ← wp−1 (mod MAX_K) of the bank just written; fold_left ← min(k_lat, wcnt); wp, wcnt ← 0 for the new wr_bank.
- k_lat: cfg_k (clamped) and cfg_en sampled on the first beat of each packet; held until that packet's s_last. Fold length used for packet N+1 is the k_lat of packet N.
- Fold: while fold_left > 0 and k_lat(current) != 0 and cfg_en latched 1, out = s_data + rd_bank[rd_ptr]; rd_ptr decrements mod MAX_K; fold_left decrements. Otherwise out = s_data.
- Arithmetic: sum computed at DATA_W+1 bits. cfg_sat=0: low DATA_W bits. cfg_sat=1: carry set → all ones, sat_pulse=1.
- Previous packet shorter than k: only its wcnt beats fold; remaining beats pass through.
- Current packet shorter than fold_left: residual fold discarded at its s_last; next packet folds this packet's tail.
- First packet after reset: rd_bank empty (fold_left=0) → passthrough.
- Single-beat packet: capture and swap in the same cycle; legal.

## Timing
- Latency 1 cycle: accepted beat appears on m_data/m_last with m_valid the next cycle.
- Output register loads when s_valid && s_ready; m_valid clears when m_ready && !s_valid.
- m_valid && !m_ready: m_data, m_last, m_valid held stable; s_ready=0; no capture or fold pointer movement.
- sat_pulse asserted in the cycle its beat is loaded into the output register.
- Reset (async assert, sync deassert use): m_valid=0, m_data=0, m_last=0, sat_pulse=0, s_ready=1, bank select=0, wp=0, wcnt=0, fold_left=0, rd_ptr=0. Reset mid-packet discards partial packet and all history; next packet is passthrough.
- No combinational path m_ready → m_data.

## Test plan
- DATA_W=8, MAX_K=8, cfg_k=3, cfg_sat=0, m_ready=1: packet 1,2,3,4,5,6 then 10,10,10,10 → first packet unchanged, second 16,15,14,10; m_last on 6 and last 10.
- Previous tail 200, next beat 100, cfg_k=1: cfg_sat=0 → 44, sat_pulse=0; cfg_sat=1 → 255, sat_pulse=1 for one cycle.
- cfg_k=4, previous packet single beat 7, next 1,1,1 → 8,1,1; then packet 0,0 → 1,1 (folds reversed 1,1 tail).
- cfg_k=3, m_ready pattern 1,0,1,0… over two 6-beat packets → output sequence identical to m_ready=1 case, data stable while stalled, no duplicates/drops.
- Reset asserted mid-packet (after 3 beats), then packet 5,5 → 5,5 passthrough; all outputs at reset values during reset.
- cfg_k=0 or cfg_en=0 on packet N+1 → passthrough; re-enable on N+2 → folds tail of N+1 (capture continued).
